keypad_event_queue: RTL and testbench

Consumes the raw 16-bit keypad snapshot `pad` produced by the row-scanning keypad reader and turns it into a stream of debounced key-press events. Each key is debounced independently on a slow sample tick. Every press edge (released to pressed) is encoded as a 4-bit key code and queued in a small FIFO. The game logic drains the FIFO through a valid/ready handshake, so no press is lost between game-loop polls.

---
 rtl/keypad_event_queue_pkg.sv | 14 +
 rtl/key_fifo.sv | 52 +++++
 rtl/keypad_event_queue.sv | 121 ++++++++++++
 tb/tb_keypad_event_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_event_queue_pkg.sv
// Keypad bit-order definitions shared by the keypad reader and the event queue.
// pad[15] is row 0 col 0 (code 0); pad[0] is row 3 col 3 (code 15).
package keypad_event_queue_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEY_CODE_W = 4;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  function automatic key_code_t key_code_of(input key_code_t bit_idx);
    return key_code_t'(NUM_KEYS - 1) - bit_idx;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO for key codes; dout reads 0 while empty.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Debounces a raw keypad snapshot per key and queues press events as key codes
// for a valid/ready consumer.
module keypad_event_queue
  import keypad_event_queue_pkg::*;
#(
  parameter int SAMPLE_DIV      = 500000,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   pad,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_ready,
  output logic [NUM_KEYS-1:0]   pressed,
  output logic                  overflow
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_KEYS-1:0] pad_meta_q, pad_s_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_KEYS-1:0] pressed_q, pressed_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic [NUM_KEYS-1:0] rise, clr_mask;
  key_code_t           sel_idx;
  logic                enc_push;
  logic                fifo_full, fifo_empty;

  assign tick = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    pressed_d = pressed_q;
    cnt_inc   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (pad_s_q[i] != pressed_q[i]) begin
          cnt_inc = cnt_q[i] + 1'b1;
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            pressed_d[i] = ~pressed_q[i];
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_inc;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Highest pending index wins, i.e. lowest key code goes first.
  always_comb begin
    sel_idx  = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pending_q[i]) sel_idx = key_code_t'(i);
    end
    enc_push = (|pending_q) && !fifo_full;
    if (enc_push) clr_mask[sel_idx] = 1'b1;
  end

  // A new press of a key still pending is merged into it and counted as lost.
  always_comb begin
    rise       = pressed_d & ~pressed_q;
    pending_d  = (pending_q & ~clr_mask) | rise;
    overflow_d = overflow_q | (|(rise & pending_q));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pad_meta_q <= '0;
      pad_s_q    <= '0;
      tick_cnt_q <= '0;
      pressed_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      pad_meta_q <= pad;
      pad_s_q    <= pad_meta_q;
      tick_cnt_q <= tick_cnt_d;
      pressed_q  <= pressed_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_CODE_W)
  ) u_key_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (enc_push),
    .din      (key_code_of(sel_idx)),
    .full     (fifo_full),
    .pop      (key_ready),
    .dout     (key_code),
    .empty    (fifo_empty)
  );

  assign key_valid = !fifo_empty;
  assign pressed   = pressed_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Scoreboard bench for keypad_event_queue: expected codes are queued when keys
// are pressed and compared as the consumer accepts events.
module tb_keypad_event_queue;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int FD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] pad      = '0;
  logic        key_ready = 1'b0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pressed;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          tick_count = 0;
  int          t0;
  logic [3:0]  sb [$];

  keypad_event_queue #(
    .SAMPLE_DIV      (SD),
    .DEBOUNCE_CYCLES (DC),
    .FIFO_DEPTH      (FD)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .pad       (pad),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .pressed   (pressed),
    .overflow  (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Time reference: cycle index since reset release; tick cycles are index % SD == SD-1.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge CLOCK_50) begin
    if (!reset && (cyc % SD) == SD - 1) tick_count++;
  end

  // Consumer side: each accepted event must match the oldest expected code.
  always @(negedge CLOCK_50) begin
    logic [3:0] exp_code;
    if (!reset && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        check("spurious_event", 32'(key_valid), 32'd0);
      end else begin
        exp_code = sb.pop_front();
        check("event_code", 32'(key_code), 32'(exp_code));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_pressed(input string tag, input int idx, input logic val, input int bound);
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (pressed[idx] !== val && n < bound);
    check(tag, 32'(pressed[idx]), 32'(val));
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (key_valid !== 1'b1 && n < bound);
    check(tag, 32'(key_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_valid",    32'(key_valid), 32'd0);
    check("rst_code",     32'(key_code),  32'd0);
    check("rst_pressed",  32'(pressed),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    reset     = 1'b0;
    key_ready = 1'b1;

    // Clean press, applied at the start of a tick period so sync delay is hidden.
    do begin
      @(posedge CLOCK_50);
      #1;
    end while ((cyc % SD) != 0);
    t0 = tick_count;
    sb.push_back(4'd0);
    pad = 16'h8000;
    wait_pressed("clean_pressed", 15, 1'b1, 100);
    check("clean_ticks",     32'(tick_count - t0), 32'(DC));
    check("clean_latency_a", 32'(key_valid), 32'd0);
    @(negedge CLOCK_50);
    check("clean_latency_b", 32'(key_valid), 32'd1);
    check("clean_code",      32'(key_code),  32'd0);
    idle(20);
    check("clean_held", 32'(pressed), 32'h8000);
    pad = 16'h0000;
    wait_pressed("clean_release", 15, 1'b0, 100);
    idle(10);

    // Bounce: pad[0] flips every tick, then settles high.
    for (int k = 0; k < 10; k++) begin
      pad[0] = ~pad[0];
      idle(SD);
    end
    check("bounce_no_press", 32'(pressed), 32'd0);
    sb.push_back(4'd15);
    pad[0] = 1'b1;
    wait_pressed("bounce_pressed", 0, 1'b1, 100);
    idle(20);
    wait_drain("bounce_drain", 20);
    pad = 16'h0000;
    wait_pressed("bounce_release", 0, 1'b0, 100);
    idle(20);

    // Simultaneous press of bits 8 and 0.
    @(posedge CLOCK_50);
    #1;
    sb.push_back(4'd7);
    sb.push_back(4'd15);
    pad = 16'h0101;
    wait_valid("sim_valid", 100);
    check("sim_first", 32'(key_code), 32'd7);
    @(negedge CLOCK_50);
    check("sim_second_valid", 32'(key_valid), 32'd1);
    check("sim_second",       32'(key_code),  32'd15);
    @(negedge CLOCK_50);
    check("sim_empty", 32'(key_valid), 32'd0);
    idle(1);
    pad = 16'h0000;
    wait_pressed("sim_release", 8, 1'b0, 100);
    idle(10);

    // Backpressure: five presses into a four-entry queue.
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back(4'(k));
    pad = 16'hF800;
    idle(40);
    check("bp_pressed",  32'(pressed),   32'hF800);
    check("bp_overflow", 32'(overflow),  32'd0);
    check("bp_valid",    32'(key_valid), 32'd1);
    check("bp_head",     32'(key_code),  32'd0);
    idle(8);
    check("bp_head_stable", 32'(key_code), 32'd0);
    key_ready = 1'b1;
    wait_drain("bp_drain", 100);
    idle(1);
    pad = 16'h0000;
    wait_pressed("bp_release", 11, 1'b0, 100);
    idle(10);

    // Overflow: second press of bit 10 while its first event is still pending.
    key_ready = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back(4'(k));
    pad = 16'hF000;
    idle(30);
    sb.push_back(4'd5);
    pad = 16'hF400;
    idle(30);
    check("ovf_pre", 32'(overflow), 32'd0);
    pad = 16'hF000;
    idle(30);
    check("ovf_released", 32'(pressed), 32'hF000);
    pad = 16'hF400;
    idle(30);
    check("ovf_set", 32'(overflow), 32'd1);
    key_ready = 1'b1;
    wait_drain("ovf_drain", 100);
    idle(20);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pad = 16'h0000;
    wait_pressed("ovf_release", 15, 1'b0, 100);
    idle(10);

    // Reset mid-operation with three queued events.
    key_ready = 1'b0;
    pad = 16'hE000;
    idle(30);
    check("mid_valid_pre", 32'(key_valid), 32'd1);
    #2;
    reset = 1'b1;
    pad   = 16'h0000;
    #1;
    check("mid_rst_valid",    32'(key_valid), 32'd0);
    check("mid_rst_pressed",  32'(pressed),   32'd0);
    check("mid_rst_overflow", 32'(overflow),  32'd0);
    idle(2);
    reset     = 1'b0;
    key_ready = 1'b1;
    idle(40);
    check("mid_no_stale", 32'(key_valid), 32'd0);
    check("sb_final",     32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
